// File: rtl/seq_booth_mul.sv
// Iterative Booth multiplier (signed/unsigned) with start/busy/done handshake and abort.
// Define SEQ_BOOTH_MUL_RADIX4_EN for radix-4 recoding (2 bits per cycle); default is radix-2.
module seq_booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

`ifdef SEQ_BOOTH_MUL_RADIX4_EN
  localparam int SH = 2;
`else
  localparam int SH = 1;
`endif
  // Extending by SH bits makes unsigned operands positive and keeps the digit count exact.
  localparam int EXT = WIDTH + SH;
  localparam int N   = EXT / SH;
  localparam int HW  = EXT + 2;
  localparam int AW  = HW + EXT;
  localparam int CW  = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc;
  logic             r_prev;
  logic [EXT-1:0]   r_a_ext;

  logic [EXT-1:0]        w_a_ext_in;
  logic [EXT-1:0]        w_b_ext_in;
  logic signed [HW-1:0]  w_a_hw;
  logic signed [HW-1:0]  w_addend;
  logic signed [HW-1:0]  w_sum;
  logic signed [AW-1:0]  w_pre;
  logic signed [AW-1:0]  w_next;
  logic                  w_prev_next;

  assign w_a_ext_in = {{SH{op_signed & a[WIDTH-1]}}, a};
  assign w_b_ext_in = {{SH{op_signed & b[WIDTH-1]}}, b};
  assign w_a_hw     = {{(HW-EXT){r_a_ext[EXT-1]}}, r_a_ext};

`ifdef SEQ_BOOTH_MUL_RADIX4_EN
  always_comb begin
    w_addend = '0;
    case ({r_acc[1], r_acc[0], r_prev})
      3'b001, 3'b010: w_addend = w_a_hw;
      3'b011:         w_addend = w_a_hw <<< 1;
      3'b100:         w_addend = -(w_a_hw <<< 1);
      3'b101, 3'b110: w_addend = -w_a_hw;
      default:        w_addend = '0;
    endcase
  end
`else
  always_comb begin
    w_addend = '0;
    case ({r_acc[0], r_prev})
      2'b01:   w_addend = w_a_hw;
      2'b10:   w_addend = -w_a_hw;
      default: w_addend = '0;
    endcase
  end
`endif

  assign w_sum       = $signed(r_acc[AW-1:EXT]) + w_addend;
  assign w_pre       = {w_sum, r_acc[EXT-1:0]};
  assign w_next      = w_pre >>> SH;
  assign w_prev_next = r_acc[SH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_prev  <= 1'b0;
      r_a_ext <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_ext <= w_a_ext_in;
            r_acc   <= {{HW{1'b0}}, w_b_ext_in};
            r_prev  <= 1'b0;
            r_cnt   <= CW'(N);
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc  <= w_next;
            r_prev <= w_prev_next;
            r_cnt  <= r_cnt - CW'(1);
            // Last digit: publish result so done and product appear together in FIN.
            if (r_cnt == CW'(1)) begin
              product <= w_next[2*WIDTH-1:0];
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
